// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: request, ALU and result bundle for alu_op_sequencer (optional flags under ALU_SEQ_FLAGS_EN)
interface alu_op_sequencer_if #(parameter int WIDTH = 8, parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_ctrl;
  logic             in_use_acc;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_ctrl;
  logic [WIDTH-1:0] alu_y;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
`ifdef ALU_SEQ_FLAGS_EN
  logic             out_zero;
  logic             out_neg;
  modport slave (input in_valid, in_a, in_b, in_ctrl, in_use_acc, alu_y, out_ready,
                 output in_ready, alu_a, alu_b, alu_ctrl, out_valid, out_y, acc, count, out_zero, out_neg);
  modport master (output in_valid, in_a, in_b, in_ctrl, in_use_acc, alu_y, out_ready,
                  input in_ready, alu_a, alu_b, alu_ctrl, out_valid, out_y, acc, count, out_zero, out_neg);
`else
  modport slave (input in_valid, in_a, in_b, in_ctrl, in_use_acc, alu_y, out_ready,
                 output in_ready, alu_a, alu_b, alu_ctrl, out_valid, out_y, acc, count);
  modport master (output in_valid, in_a, in_b, in_ctrl, in_use_acc, alu_y, out_ready,
                  input in_ready, alu_a, alu_b, alu_ctrl, out_valid, out_y, acc, count);
`endif
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: FIFO-buffered issue stage for a combinational ALU with accumulator chaining (optional out_zero/out_neg under ALU_SEQ_FLAGS_EN)
module alu_op_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  alu_op_sequencer_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       ctrl;
    logic             use_acc;
  } req_t;
  req_t             mem_q [DEPTH];
  req_t             mem_d [DEPTH];
  req_t             head;
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2:0]       op_ctrl_q, op_ctrl_d;
  logic [WIDTH-1:0] out_y_q, out_y_d, acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic             push, pop;
  assign bus.in_ready  = count_q < CW'(DEPTH);
  assign push          = bus.in_valid && bus.in_ready;
  assign pop           = (count_q != '0) && (state_q == IDLE || (state_q == HOLD && bus.out_ready));
  assign head          = mem_q[rd_q];
  assign bus.alu_a     = op_a_q;
  assign bus.alu_b     = op_b_q;
  assign bus.alu_ctrl  = op_ctrl_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_y     = out_y_q;
  assign bus.acc       = acc_q;
  assign bus.count     = count_q;
  // FIFO next state: write at wr pointer, read at rd pointer; pop never feeds in_ready
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = '{a: bus.in_a, b: bus.in_b, ctrl: bus.in_ctrl, use_acc: bus.in_use_acc};
    wr_d    = push ? wr_q + PW'(1) : wr_q;
    rd_d    = pop ? rd_q + PW'(1) : rd_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  // Issue FSM: pop loads the op register (accumulator resolved here), EXEC captures, HOLD waits for the consumer
  always_comb begin
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_ctrl_d   = op_ctrl_q;
    out_y_d     = out_y_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    if (pop) begin
      op_a_d    = head.use_acc ? acc_q : head.a;
      op_b_d    = head.b;
      op_ctrl_d = head.ctrl;
      state_d   = EXEC;
    end
    if (state_q == EXEC) begin
      out_y_d     = bus.alu_y;
      acc_d       = bus.alu_y;
      out_valid_d = 1'b1;
      state_d     = HOLD;
    end
    if (state_q == HOLD && bus.out_ready) begin
      out_valid_d = 1'b0;
      state_d     = pop ? EXEC : IDLE;
    end
    if (state_q == 2'd3) state_d = IDLE;
  end
  // FIFO storage carries no reset; the pointers and count define emptiness
  always_ff @(posedge clk) mem_q <= mem_d;
  // Control and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      state_q     <= IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_ctrl_q   <= '0;
      out_y_q     <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_ctrl_q   <= op_ctrl_d;
      out_y_q     <= out_y_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
    end
  end
`ifdef ALU_SEQ_FLAGS_EN
  logic zero_q, zero_d, neg_q, neg_d;
  assign bus.out_zero = zero_q;
  assign bus.out_neg  = neg_q;
  // Result flags captured together with out_y
  always_comb begin
    zero_d = (state_q == EXEC) ? (bus.alu_y == '0) : zero_q;
    neg_d  = (state_q == EXEC) ? bus.alu_y[WIDTH-1] : neg_q;
  end
  // Flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      zero_q <= zero_d;
      neg_q  <= neg_d;
    end
  end
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random stimulus against an in-order result-queue model
module tb_alu_op_sequencer;
  localparam int W = 8;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] macc = '0;
  alu_op_sequencer_if #(.WIDTH(W), .DEPTH(D)) bus();
  alu_op_sequencer #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c);
    case (c)
      3'd0: alu_f = a + b;
      3'd1: alu_f = a & b;
      3'd2: alu_f = a - b;
      3'd3: alu_f = a | b;
      3'd4: alu_f = a ^ b;
      3'd5: alu_f = a << 1;
      3'd6: alu_f = a >> 1;
      default: alu_f = ~a;
    endcase
  endfunction
  always_comb bus.alu_y = alu_f(bus.alu_a, bus.alu_b, bus.alu_ctrl);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Scoreboard: every accepted request yields one expected result in order; acc chains on the previous result
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      macc = '0;
    end else begin
      if (bus.out_valid) begin
        chk("result_pending", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          chk("out_y", bus.out_y, exp_q[0]);
          chk("acc", bus.acc, exp_q[0]);
`ifdef ALU_SEQ_FLAGS_EN
          chk("out_zero", bus.out_zero, exp_q[0] == '0);
          chk("out_neg", bus.out_neg, exp_q[0][W-1]);
`endif
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        macc = alu_f(bus.in_use_acc ? macc : bus.in_a, bus.in_b, bus.in_ctrl);
        exp_q.push_back(macc);
      end
    end
  end
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] c, input logic u);
    logic rdy;
    logic ok;
    ok = 1'b0;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_ctrl = c;
    bus.in_use_acc = u;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      ok = rdy;
    end
    bus.in_valid = 1'b0;
    chk("push_timeout", 32'(ok), 1);
  endtask
  task automatic wait_out();
    for (int i = 0; i < 50 && !bus.out_valid; i++) cyc(1);
    chk("out_timeout", 32'(bus.out_valid), 1);
  endtask
  task automatic drain();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) begin
      for (int i = 0; i < 300 && (bus.count != 0 || bus.out_valid); i++) cyc(1);
      cyc(2);
    end
    chk("drained", 32'(bus.count == 0 && !bus.out_valid), 1);
    chk("queue_empty", exp_q.size(), 0);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_ctrl = '0;
    bus.in_use_acc = 1'b0;
    bus.out_ready = 1'b0;
    #2 rst_n = 1'b0;
    cyc(3);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_acc", bus.acc, 0);
    chk("rst_out_y", bus.out_y, 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    cyc(2);
    bus.out_ready = 1'b1;
    push(8'h3D, 8'h06, 3'd0, 1'b0);
    chk("lat_t0_valid", bus.out_valid, 0);
    cyc(1);
    chk("lat_t1_valid", bus.out_valid, 0);
    cyc(1);
    chk("lat_t2_valid", bus.out_valid, 1);
    chk("single_out_y", bus.out_y, 8'h43);
    chk("single_acc", bus.acc, 8'h43);
    cyc(1);
    chk("single_held_once", bus.out_valid, 0);
    cyc(2);
    push(8'h3D, 8'h06, 3'd0, 1'b0);
    push(8'hAA, 8'h03, 3'd2, 1'b1);
    wait_out();
    chk("chain_r1", bus.out_y, 8'h43);
    cyc(1);
    chk("chain_alu_a", bus.alu_a, 8'h43);
    chk("chain_alu_ctrl", bus.alu_ctrl, 3'd2);
    wait_out();
    chk("chain_r2", bus.out_y, 8'h40);
    cyc(2);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(W'($urandom), W'($urandom), 3'($urandom), 1'b0);
    cyc(2);
    chk("full_count", bus.count, 4);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_out_valid", bus.out_valid, 1);
    bus.in_a = 8'h11;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    cyc(1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("full_push_refused", bus.count, 3);
    drain();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(W'($urandom), W'($urandom), 3'($urandom), 1'($urandom));
    cyc(2);
    chk("pp_count_before", bus.count, 2);
    bus.in_a = 8'h5A;
    bus.in_b = 8'h21;
    bus.in_ctrl = 3'd4;
    bus.in_use_acc = 1'b0;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    cyc(1);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    chk("pp_count_after", bus.count, 2);
    drain();
    push(8'hFF, 8'hFF, 3'd2, 1'b0);
    wait_out();
    chk("flags_sub_y", bus.out_y, 8'h00);
`ifdef ALU_SEQ_FLAGS_EN
    chk("flags_zero1", bus.out_zero, 1);
    chk("flags_neg1", bus.out_neg, 0);
`endif
    cyc(1);
    push(8'hFF, 8'hFF, 3'd0, 1'b0);
    wait_out();
    chk("flags_add_y", bus.out_y, 8'hFE);
`ifdef ALU_SEQ_FLAGS_EN
    chk("flags_zero2", bus.out_zero, 0);
    chk("flags_neg2", bus.out_neg, 1);
`endif
    cyc(1);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(W'($urandom), W'($urandom), 3'($urandom), 1'b0);
    cyc(2);
    chk("prerst_count", bus.count, 3);
    chk("prerst_out_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_count", bus.count, 0);
    chk("async_acc", bus.acc, 0);
    cyc(2);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    cyc(10);
    chk("postrst_no_stale", bus.out_valid, 0);
    chk("postrst_count", bus.count, 0);
    for (int i = 0; i < 500; i++) begin
      bus.in_valid = ($urandom_range(0, 9) < 6);
      bus.in_a = W'($urandom);
      bus.in_b = W'($urandom);
      bus.in_ctrl = 3'($urandom);
      bus.in_use_acc = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 9) < 5);
      cyc(1);
    end
    drain();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
